// File: rtl/buscador_nonce_pkg.sv
// Shared widths and FSM state encoding for the nonce-search controller.
package buscador_nonce_pkg;

   localparam int unsigned BOUNTY_W = 24;
   localparam int unsigned NONCE_W  = 32;
   localparam int unsigned HASH_W   = 24;
   localparam int unsigned TARGET_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CARGA   = 3'd1,
      ST_LANZA   = 3'd2,
      ST_ESPERA  = 3'd3,
      ST_COMPARA = 3'd4,
      ST_REPORTA = 3'd5,
      ST_PAUSA   = 3'd6,
      ST_FIN     = 3'd7
   } estado_t;

endpackage

// File: rtl/buscador_nonce_if.sv
// Handshake with the external hash core: launch pulse plus operands out, done pulse plus result back.
interface buscador_nonce_if;
   import buscador_nonce_pkg::*;

   logic                hash_start;
   logic [BOUNTY_W-1:0] hash_bounty;
   logic [NONCE_W-1:0]  hash_nonce;
   logic                hash_done;
   logic [HASH_W-1:0]   hash_in;

   modport master (
      output hash_start, hash_bounty, hash_nonce,
      input  hash_done, hash_in
   );

   modport slave (
      input  hash_start, hash_bounty, hash_nonce,
      output hash_done, hash_in
   );
endinterface

// File: rtl/buscador_nonce_comparador_target.sv
// Difficulty check: the two most significant hash bytes must both be below target.
module comparador_target
   import buscador_nonce_pkg::*;
(
   input  logic [HASH_W-1:0]   i_hash,
   input  logic [TARGET_W-1:0] i_target,
   output logic                o_pasa_c
);

   logic [TARGET_W-1:0] w_alto;
   logic [TARGET_W-1:0] w_medio;
   logic                w_unused_bajo;

   assign w_alto        = i_hash[HASH_W-1 -: TARGET_W];
   assign w_medio       = i_hash[HASH_W-TARGET_W-1 -: TARGET_W];
   // Low byte plays no part in the difficulty rule.
   assign w_unused_bajo = ^i_hash[HASH_W-2*TARGET_W-1:0];

   // Unsigned strict compare; target=0 can never pass.
   assign o_pasa_c = (w_alto < i_target) && (w_medio < i_target);

endmodule

// File: rtl/buscador_nonce.sv
// Nonce-search controller: per entry, sweeps nonces through the hash core until one meets target.
module buscador_nonce
   import buscador_nonce_pkg::*;
#(
   parameter logic [NONCE_W-1:0] NONCE_INI = '0,
   parameter logic [NONCE_W-1:0] NONCE_MAX = '1
)(
   input  logic                clk,
   input  logic                reset_L,
   input  logic                habilitar,
   input  logic [BOUNTY_W-1:0] bounty_in,
   input  logic [TARGET_W-1:0] target,
   input  logic                fin,
   buscador_nonce_if.master    hash_bus,
   output logic                valid,
   output logic [BOUNTY_W-1:0] bounty,
   output logic [NONCE_W-1:0]  nonce_valido,
   output logic                agotado,
   output logic                ocupado
);

   estado_t             r_estado;
   estado_t             w_estado_sig;
   logic [BOUNTY_W-1:0] r_bounty;
   logic [NONCE_W-1:0]  r_nonce;
   logic [HASH_W-1:0]   r_hash;
   logic                r_hash_start;
   logic                r_valid;
   logic                r_ocupado;
   logic [NONCE_W-1:0]  r_nonce_valido;
   logic                r_agotado;
   logic                w_pasa;
   logic                w_ultimo;

   comparador_target u_comparador (
      .i_hash   (r_hash),
      .i_target (target),
      .o_pasa_c (w_pasa)
   );

   assign w_ultimo = (r_nonce == NONCE_MAX);

   // Next-state logic; the exhaustion check is taken before any increment so the nonce never wraps.
   always_comb begin
      w_estado_sig = r_estado;
      unique case (r_estado)
         ST_IDLE:    if (habilitar) w_estado_sig = ST_CARGA;
         ST_CARGA:   w_estado_sig = ST_LANZA;
         ST_LANZA:   w_estado_sig = ST_ESPERA;
         ST_ESPERA:  if (hash_bus.hash_done) w_estado_sig = ST_COMPARA;
         ST_COMPARA: w_estado_sig = (w_pasa || w_ultimo) ? ST_REPORTA : ST_LANZA;
         ST_REPORTA: w_estado_sig = ST_PAUSA;
         ST_PAUSA:   w_estado_sig = fin ? ST_FIN : ST_CARGA;
         ST_FIN:     if (!habilitar) w_estado_sig = ST_IDLE;
         default:    w_estado_sig = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) r_estado <= ST_IDLE;
      else          r_estado <= w_estado_sig;
   end

   // Pulse/status outputs decoded from the next state so they are registered yet coincide with the state.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_hash_start <= 1'b0;
         r_valid      <= 1'b0;
         r_ocupado    <= 1'b0;
      end else begin
         r_hash_start <= (w_estado_sig == ST_LANZA);
         r_valid      <= (w_estado_sig == ST_REPORTA);
         r_ocupado    <= (w_estado_sig != ST_IDLE);
      end
   end

   // Operand, nonce counter and result registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_bounty       <= '0;
         r_nonce        <= '0;
         r_hash         <= '0;
         r_nonce_valido <= '0;
         r_agotado      <= 1'b0;
      end else begin
         if (r_estado == ST_CARGA) begin
            r_bounty <= bounty_in;
            r_nonce  <= NONCE_INI;
         end
         if ((r_estado == ST_ESPERA) && hash_bus.hash_done) begin
            r_hash <= hash_bus.hash_in;
         end
         if (r_estado == ST_COMPARA) begin
            if (w_pasa) begin
               r_nonce_valido <= r_nonce;
               r_agotado      <= 1'b0;
            end else if (w_ultimo) begin
               r_nonce_valido <= NONCE_MAX;
               r_agotado      <= 1'b1;
            end else begin
               r_nonce <= r_nonce + NONCE_W'(1);
            end
         end
      end
   end

   assign hash_bus.hash_start  = r_hash_start;
   assign hash_bus.hash_bounty = r_bounty;
   assign hash_bus.hash_nonce  = r_nonce;
   assign valid                = r_valid;
   assign bounty               = r_bounty;
   assign nonce_valido         = r_nonce_valido;
   assign agotado              = r_agotado;
   assign ocupado              = r_ocupado;

endmodule
